// File: rtl/ysyx_23060096_imem_resp_if.sv
// Fetch-side bus between the core and the instruction-memory responder:
// request channel, response channel and the instruction-store loader port.
interface ysyx_23060096_imem_resp_if #(
  parameter int DEPTH = 1024
);
  localparam int IW = $clog2(DEPTH);

  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_inst;
  logic [1:0]    rsp_err;
  logic          ld_en;
  logic [IW-1:0] ld_idx;
  logic [31:0]   ld_data;

  // Core side: issues fetches, consumes responses, loads the store.
  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_idx, ld_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  // Responder side.
  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_idx, ld_data,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_23060096_imem_resp.sv
// Instruction-memory responder: decodes a PC, reads a loadable word array,
// carries data/err through a fixed-latency valid-tagged pipe and queues the
// result in an in-order response FIFO. Credits (outstanding counter) bound
// the in-flight requests to QDEPTH, so neither the pipe nor the FIFO can
// overflow and the pipe never needs to stall.
module ysyx_23060096_imem_resp #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2,
  parameter int          QDEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060096_imem_resp_if.slave    bus
);

  localparam int IW   = $clog2(DEPTH);
  // Registered pipe stages ahead of the FIFO; the FIFO write is the last
  // of the LATENCY register stages. One dummy stage exists when LATENCY=1.
  localparam int PSTG = (LATENCY > 1) ? (LATENCY - 1) : 1;
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW   = $clog2(QDEPTH + 1);

  // Wrapping pointer increment for the response FIFO.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          consume;
  logic          head_vld;
  logic [31:0]   word_off;
  logic [31:0]   dec_data;
  logic [1:0]    dec_err;

  logic          stg_vld_d  [PSTG];
  logic          stg_vld_q  [PSTG];
  logic [31:0]   stg_data_d [PSTG];
  logic [31:0]   stg_data_q [PSTG];
  logic [1:0]    stg_err_d  [PSTG];
  logic [1:0]    stg_err_q  [PSTG];

  logic          wr_en;
  logic [31:0]   wr_data;
  logic [1:0]    wr_err;

  logic [31:0]   fifo_data_d [QDEPTH];
  logic [31:0]   fifo_data_q [QDEPTH];
  logic [1:0]    fifo_err_d  [QDEPTH];
  logic [1:0]    fifo_err_q  [QDEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] fcnt_d, fcnt_q;
  logic [CW-1:0] out_d, out_q;

  // Handshakes; ready depends only on credit state (and reset).
  assign bus.req_ready = !rst && (out_q < CW'(QDEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign head_vld      = (fcnt_q != {CW{1'b0}});
  assign consume       = head_vld && bus.rsp_ready;

  // Response outputs come straight from the FIFO head registers.
  assign bus.rsp_valid = head_vld;
  assign bus.rsp_inst  = head_vld ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign bus.rsp_err   = head_vld ? fifo_err_q[rd_ptr_q]  : 2'b00;

  // Address decode and array read in the accept cycle; misaligned wins.
  always_comb begin
    word_off = (bus.req_addr - BASE) >> 2;
    dec_data = 32'h0;
    dec_err  = 2'b00;
    if (bus.req_addr[1:0] != 2'b00) begin
      dec_err = 2'b01;
    end else if ((bus.req_addr < BASE) || (word_off >= 32'(DEPTH))) begin
      dec_err = 2'b10;
    end else begin
      dec_data = mem_q[word_off[IW-1:0]];
    end
  end

  // Loader port; the store is never cleared by reset. A same-edge read
  // above sees the old word because the read is combinational before the edge.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem_q[bus.ld_idx] <= bus.ld_data;
    end
  end

  // Pipe shift: stage 0 takes the decode, later stages take their predecessor.
  always_comb begin
    for (int i = 0; i < PSTG; i++) begin
      stg_vld_d[i]  = stg_vld_q[i];
      stg_data_d[i] = stg_data_q[i];
      stg_err_d[i]  = stg_err_q[i];
    end
    stg_vld_d[0]  = accept;
    stg_data_d[0] = dec_data;
    stg_err_d[0]  = dec_err;
    for (int i = 1; i < PSTG; i++) begin
      stg_vld_d[i]  = stg_vld_q[i-1];
      stg_data_d[i] = stg_data_q[i-1];
      stg_err_d[i]  = stg_err_q[i-1];
    end
  end

  // Pipe stage registers; reset drops every in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PSTG; i++) begin
        stg_vld_q[i]  <= 1'b0;
        stg_data_q[i] <= 32'h0;
        stg_err_q[i]  <= 2'b00;
      end
    end else begin
      for (int i = 0; i < PSTG; i++) begin
        stg_vld_q[i]  <= stg_vld_d[i];
        stg_data_q[i] <= stg_data_d[i];
        stg_err_q[i]  <= stg_err_d[i];
      end
    end
  end

  // FIFO write source: the decode itself when LATENCY=1, else the last stage.
  always_comb begin
    if (LATENCY == 1) begin
      wr_en   = accept;
      wr_data = dec_data;
      wr_err  = dec_err;
    end else begin
      wr_en   = stg_vld_q[PSTG-1];
      wr_data = stg_data_q[PSTG-1];
      wr_err  = stg_err_q[PSTG-1];
    end
  end

  // FIFO and credit next-state.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      fifo_data_d[i] = fifo_data_q[i];
      fifo_err_d[i]  = fifo_err_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    out_d    = out_q;

    if (wr_en) begin
      fifo_data_d[wr_ptr_q] = wr_data;
      fifo_err_d[wr_ptr_q]  = wr_err;
      wr_ptr_d              = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (consume) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en, consume})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase

    case ({accept, consume})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  // FIFO storage, pointers and credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_data_q[i] <= 32'h0;
        fifo_err_q[i]  <= 2'b00;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      fcnt_q   <= {CW{1'b0}};
      out_q    <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_err_q[i]  <= fifo_err_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      out_q    <= out_d;
    end
  end

endmodule
